rpn_stack_ctrl: RTL and testbench
=================================

// Module: rpn_stack_ctrl
// PURPOSE
//   Postfix (RPN) expression evaluator that sequences an external Stack instance.
//   Accepts a token stream over a valid/ready handshake and pushes operands.
//   Applies binary operators as pop-then-replace on the stack and emits the result on EVAL.
//   Sits between a token source and Stack; the Stack receives the same clk/rst.
// PARAMETERS
//   WIDTH  4   operand/result width; must match Stack WIDTH; WIDTH >= 2
//   DEPTH  16  stack capacity; must match Stack SIZE
// PORTS
//   clk        in   1      clock; all state updates on posedge
//   rst        in   1      synchronous, active-high reset
//   tok_valid  in   1      token present
//   tok_ready  out  1      controller accepts token this cycle
//   tok_is_op  in   1      1 = operator token, 0 = operand token
//   tok_data   in   WIDTH  operand value; for operators, opcode in tok_data[1:0]
//   stk_push   out  1      Stack push strobe
//   stk_pop    out  1      Stack pop strobe (push&pop together = replace top)
//   stk_din    out  WIDTH  Stack write data
//   stk_dout   in   WIDTH  Stack top-of-stack (combinational)
//   stk_full   in   1      Stack full flag (informational; internal depth governs)
//   res_valid  out  1      one-cycle pulse; res_data valid
//   res_data   out  WIDTH  evaluated result, held until next res_valid
//   err        out  1      sticky error; cleared only by rst
// BEHAVIOUR
// - Reset: state=IDLE, depth=0, err=0, res_valid=0, res_data=0, b_reg=0.
//   While rst=1: tok_ready=0, stk_push=0, stk_pop=0.
// - Internal depth counter (0..DEPTH) mirrors stack occupancy and governs all bounds checks.
// - Accept condition: tok_valid & tok_ready. Strobes are combinational from state + accept.
// - States: IDLE, APPLY, ERR. tok_ready=1 only in IDLE.
// - IDLE, operand accepted:
//     depth==DEPTH -> ERR, no strobe.
//     else stk_push=1, stk_din=tok_data, depth+1.
// - IDLE, operator accepted with opcode 00 ADD, 01 SUB, or 10 MUL:
//     depth<2 -> ERR, no strobe.
//     else b_reg<=stk_dout, op_reg<=opcode, stk_pop=1, depth-1, go to APPLY.
// - APPLY (1 cycle): a=stk_dout; stk_push=1, stk_pop=1, stk_din=f(a,b_reg);
//   depth unchanged; go to IDLE. An operator therefore costs 2 cycles.
// - Arithmetic is modulo 2^WIDTH:
//     ADD a+b; SUB a-b (a = deeper operand, b = former top); MUL low WIDTH bits of a*b.
// - IDLE, operator with opcode 11 EVAL:
//     depth!=1 -> ERR.
//     else stk_pop=1, res_data<=stk_dout, depth<=0, res_valid=1 on the next cycle.
// - ERR: err=1, tok_ready=0, no strobes. The state is left only by rst.
// - Error entry does not modify the stack or depth.
// - tok_valid with tok_ready=0: the token is held by the source, not consumed.
// - rst mid-operation (e.g. in APPLY): no strobe that cycle.
//   The controller returns to IDLE with depth=0 and a pending res_valid is dropped.
// TESTING
//   T1: tokens 3,4,ADD,EVAL -> res_valid once, res_data=7, err=0, depth=0.
//   T2: 5,3,SUB,2,MUL,EVAL -> res_data=4; check the APPLY cycle drives
//       stk_push=stk_pop=1 with stk_din=2 after SUB.
//   T3 (wrap): 15,1,ADD,EVAL -> res_data=0; 0,1,SUB,EVAL -> res_data=15;
//       7,3,MUL,EVAL -> res_data=5.
//   T4 (underflow): 3,ADD -> err=1, tok_ready=0, no stk_pop;
//       further tok_valid ignored until rst.
//   T5 (overflow/EVAL): 17 operands -> 17th sets err, stk_push stays 0;
//       separately 1,2,EVAL -> err=1, res_valid never pulses.
//   T6 (reset): assert rst during APPLY -> next cycle depth=0, err=0,
//       tok_ready=1; then 6,EVAL -> res_data=6.

Source files
------------

// File: rtl/rpn_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rpn_stack_ctrl
// Purpose  : Postfix (RPN) expression evaluator that sequences an external
//            stack. Operand tokens are pushed. A binary operator pops the top
//            into b, then replaces the new top with f(a, b) one cycle later.
//            EVAL pops the single remaining value and presents it as the
//            result. Any bounds violation locks the controller in an error
//            state until reset.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            tok_valid/tok_ready           - token handshake
//            tok_is_op, tok_data           - token kind and payload/opcode
//            stk_push/stk_pop/stk_din      - stack command strobes and write data
//            stk_dout, stk_full            - stack top-of-stack and full flag
//            res_valid, res_data           - result pulse and held result
//            err                           - sticky error flag
// Revision : 1.0 - initial release
// ============================================================================
module rpn_stack_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic             tok_is_op,
    input  logic [WIDTH-1:0] tok_data,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_din,
    input  logic [WIDTH-1:0] stk_dout,
    input  logic             stk_full,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             err
);

    localparam int DW = $clog2(DEPTH + 1);

    localparam logic [DW-1:0] c_depth_full = DW'(DEPTH);
    localparam logic [DW-1:0] c_depth_one  = DW'(1);
    localparam logic [DW-1:0] c_depth_two  = DW'(2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_ERR   = 2'd2;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_EVAL = 2'b11;

    logic [1:0]       r_state;
    logic [DW-1:0]    r_depth;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;

    logic             w_accept;
    logic [1:0]       w_opcode;
    logic [WIDTH-1:0] w_result;
    logic [1:0]       w_state_nxt;
    logic [DW-1:0]    w_depth_nxt;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_din;
    logic             w_load_b;
    logic             w_eval;

    // The internal depth counter is authoritative for bounds checks, so the
    // stack's own full flag is deliberately left unused.
    logic             w_unused_full;
    assign w_unused_full = stk_full;

    assign tok_ready = !rst && (r_state == S_IDLE);
    assign w_accept  = tok_valid && tok_ready;
    assign w_opcode  = tok_data[1:0];

    // In APPLY, stk_dout is the deeper operand a; r_b holds the former top.
    always_comb begin
        case (r_op)
            OP_ADD:  w_result = stk_dout + r_b;
            OP_SUB:  w_result = stk_dout - r_b;
            default: w_result = stk_dout * r_b;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_depth_nxt = r_depth;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_din       = tok_data;
        w_load_b    = 1'b0;
        w_eval      = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!tok_is_op) begin
                            if (r_depth == c_depth_full) begin
                                w_state_nxt = S_ERR;
                            end else begin
                                w_push      = 1'b1;
                                w_depth_nxt = r_depth + c_depth_one;
                            end
                        end else if (w_opcode == OP_EVAL) begin
                            if (r_depth != c_depth_one) begin
                                w_state_nxt = S_ERR;
                            end else begin
                                w_pop       = 1'b1;
                                w_eval      = 1'b1;
                                w_depth_nxt = '0;
                            end
                        end else begin
                            if (r_depth < c_depth_two) begin
                                w_state_nxt = S_ERR;
                            end else begin
                                w_pop       = 1'b1;
                                w_load_b    = 1'b1;
                                w_depth_nxt = r_depth - c_depth_one;
                                w_state_nxt = S_APPLY;
                            end
                        end
                    end
                end
                S_APPLY: begin
                    // push and pop together replace the top with the result
                    w_push      = 1'b1;
                    w_pop       = 1'b1;
                    w_din       = w_result;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_ERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_depth     <= '0;
            r_b         <= '0;
            r_op        <= OP_ADD;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_depth     <= w_depth_nxt;
            r_res_valid <= w_eval;
            if (w_load_b) begin
                r_b  <= stk_dout;
                r_op <= w_opcode;
            end
            if (w_eval) begin
                r_res_data <= stk_dout;
            end
        end
    end

    assign stk_push  = w_push;
    assign stk_pop   = w_pop;
    assign stk_din   = w_din;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign err       = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_rpn_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rpn_stack_ctrl
// Purpose  : Self-checking bench for rpn_stack_ctrl with a behavioural stack
//            attached, directed token tables, hand-written corner sequences
//            and a randomized token stream checked against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rpn_stack_ctrl;

    localparam int WIDTH = 4;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tok_valid = 1'b0;
    logic             tok_ready;
    logic             tok_is_op = 1'b0;
    logic [WIDTH-1:0] tok_data = '0;
    logic             stk_push;
    logic             stk_pop;
    logic [WIDTH-1:0] stk_din;
    logic [WIDTH-1:0] stk_dout;
    logic             stk_full;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             err;

    int total = 0;
    int bad   = 0;

    rpn_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_is_op (tok_is_op),
        .tok_data  (tok_data),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_din   (stk_din),
        .stk_dout  (stk_dout),
        .stk_full  (stk_full),
        .res_valid (res_valid),
        .res_data  (res_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    // behavioural stack
    logic [WIDTH-1:0] mem [DEPTH];
    int               sp;

    always @(posedge clk) begin
        if (rst) begin
            sp <= 0;
        end else if (stk_push && stk_pop) begin
            if (sp > 0) mem[sp-1] <= stk_din;
        end else if (stk_push) begin
            if (sp < DEPTH) begin
                mem[sp] <= stk_din;
                sp      <= sp + 1;
            end
        end else if (stk_pop) begin
            if (sp > 0) sp <= sp - 1;
        end
    end

    always_comb begin
        stk_dout = '0;
        if (sp > 0) stk_dout = mem[sp-1];
    end
    assign stk_full = (sp == DEPTH);

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (got running, want finished)");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        tok_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_ready", tok_ready, 0);
        check("rst_strobe", {stk_push, stk_pop}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Presents one token, waits a bounded time for acceptance, then samples
    // outputs on the following negedge (APPLY cycle / result cycle).
    task automatic send_token(input bit op, input logic [3:0] d,
                              output bit acc, output bit pre_push, output bit pre_pop,
                              output bit e, output bit rv, output logic [3:0] rd,
                              output bit ap_push, output bit ap_pop, output logic [3:0] ap_din);
        acc = 0; pre_push = 0; pre_pop = 0;
        @(negedge clk);
        tok_valid = 1'b1;
        tok_is_op = op;
        tok_data  = d;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (tok_ready) begin
                pre_push = stk_push;
                pre_pop  = stk_pop;
                acc      = 1;
                break;
            end
            pre_push |= stk_push;
            pre_pop  |= stk_pop;
            @(negedge clk);
            #1;
        end
        if (acc) begin
            @(negedge clk);
        end
        tok_valid = 1'b0;
        #1;
        e       = err;
        rv      = res_valid;
        rd      = res_data;
        ap_push = stk_push;
        ap_pop  = stk_pop;
        ap_din  = stk_din;
    endtask

    typedef struct {
        bit         rst_first;
        bit         is_op;
        logic [3:0] data;
        bit         exp_acc;
        bit         exp_err;
        bit         exp_res;
        logic [3:0] exp_data;
        bit         chk_ap;
        logic [3:0] ap_din;
    } vec_t;

    function automatic vec_t mk(bit r, bit op, int d, bit a, bit e, bit rs, int rd, bit ca, int ad);
        vec_t v;
        v.rst_first = r;  v.is_op = op;   v.data = 4'(d);
        v.exp_acc   = a;  v.exp_err = e;  v.exp_res = rs;
        v.exp_data  = 4'(rd); v.chk_ap = ca; v.ap_din = 4'(ad);
        return v;
    endfunction

    // queue model state for random stimulus
    int  mq[$];
    bit  m_err;

    initial begin
        vec_t tbl[$];
        bit acc, pp, pq, e, rv, ap, aq, prev_err, new_err;
        logic [3:0] rd, ad;

        // T1
        tbl.push_back(mk(1,0,3, 1,0,0,0, 0,0));
        tbl.push_back(mk(0,0,4, 1,0,0,0, 0,0));
        tbl.push_back(mk(0,1,0, 1,0,0,0, 1,7));
        tbl.push_back(mk(0,1,3, 1,0,1,7, 0,0));
        // T2
        tbl.push_back(mk(1,0,5, 1,0,0,0, 0,0));
        tbl.push_back(mk(0,0,3, 1,0,0,0, 0,0));
        tbl.push_back(mk(0,1,1, 1,0,0,0, 1,2));
        tbl.push_back(mk(0,0,2, 1,0,0,0, 0,0));
        tbl.push_back(mk(0,1,2, 1,0,0,0, 1,4));
        tbl.push_back(mk(0,1,3, 1,0,1,4, 0,0));
        // T3 wrap cases
        tbl.push_back(mk(0,0,15, 1,0,0,0, 0,0));
        tbl.push_back(mk(0,0,1,  1,0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,  1,0,0,0, 1,0));
        tbl.push_back(mk(0,1,3,  1,0,1,0, 0,0));
        tbl.push_back(mk(0,0,0,  1,0,0,0, 0,0));
        tbl.push_back(mk(0,0,1,  1,0,0,0, 0,0));
        tbl.push_back(mk(0,1,1,  1,0,0,0, 1,15));
        tbl.push_back(mk(0,1,3,  1,0,1,15,0,0));
        tbl.push_back(mk(0,0,7,  1,0,0,0, 0,0));
        tbl.push_back(mk(0,0,3,  1,0,0,0, 0,0));
        tbl.push_back(mk(0,1,2,  1,0,0,0, 1,5));
        tbl.push_back(mk(0,1,3,  1,0,1,5, 0,0));
        // T4 underflow, then tokens ignored
        tbl.push_back(mk(1,0,3, 1,0,0,0, 0,0));
        tbl.push_back(mk(0,1,0, 1,1,0,0, 0,0));
        tbl.push_back(mk(0,0,5, 0,1,0,0, 0,0));
        tbl.push_back(mk(0,1,3, 0,1,0,0, 0,0));
        // T5 EVAL with depth 2
        tbl.push_back(mk(1,0,1, 1,0,0,0, 0,0));
        tbl.push_back(mk(0,0,2, 1,0,0,0, 0,0));
        tbl.push_back(mk(0,1,3, 1,1,0,0, 0,0));
        tbl.push_back(mk(0,1,0, 0,1,0,0, 0,0));

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", tok_ready, 1);
        check("reset_err", err, 0);
        check("reset_res_valid", res_valid, 0);
        check("reset_res_data", res_data, 0);

        prev_err = 0;
        foreach (tbl[k]) begin
            if (tbl[k].rst_first) begin
                do_reset();
                prev_err = 0;
            end
            send_token(tbl[k].is_op, tbl[k].data, acc, pp, pq, e, rv, rd, ap, aq, ad);
            new_err = tbl[k].exp_err && !prev_err;
            check($sformatf("v%0d_acc", k), acc, tbl[k].exp_acc);
            check($sformatf("v%0d_err", k), e, tbl[k].exp_err);
            check($sformatf("v%0d_push", k), pp, (tbl[k].exp_acc && !new_err && !tbl[k].is_op) ? 1 : 0);
            check($sformatf("v%0d_pop", k),  pq, (tbl[k].exp_acc && !new_err && tbl[k].is_op) ? 1 : 0);
            check($sformatf("v%0d_res_valid", k), rv, tbl[k].exp_res);
            if (tbl[k].exp_res) check($sformatf("v%0d_res_data", k), rd, tbl[k].exp_data);
            if (tbl[k].chk_ap) begin
                check($sformatf("v%0d_apply_strobes", k), {ap, aq}, 3);
                check($sformatf("v%0d_apply_din", k), ad, tbl[k].ap_din);
            end
            prev_err = tbl[k].exp_err;
        end

        // T5 overflow: 16 operands fit, the 17th errors without a push
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            send_token(0, 4'(i), acc, pp, pq, e, rv, rd, ap, aq, ad);
            if (!acc || !pp || e) check($sformatf("fill%0d_acc_push_err", i), {acc, pp, e}, 3'b110);
        end
        total++;
        send_token(0, 4'd9, acc, pp, pq, e, rv, rd, ap, aq, ad);
        check("ovf_acc", acc, 1);
        check("ovf_push", pp, 0);
        check("ovf_err", e, 1);
        check("ovf_ready", tok_ready, 0);

        // T6: reset during APPLY
        do_reset();
        send_token(0, 4'd2, acc, pp, pq, e, rv, rd, ap, aq, ad);
        send_token(0, 4'd3, acc, pp, pq, e, rv, rd, ap, aq, ad);
        @(negedge clk);
        tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 4'd0;
        #1;
        check("t6_ready_before_op", tok_ready, 1);
        @(negedge clk);
        tok_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_apply_strobes_in_rst", {stk_push, stk_pop}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_ready_after_rst", tok_ready, 1);
        check("t6_err_after_rst", err, 0);
        send_token(0, 4'd6, acc, pp, pq, e, rv, rd, ap, aq, ad);
        send_token(1, 4'd3, acc, pp, pq, e, rv, rd, ap, aq, ad);
        check("t6_eval_valid", rv, 1);
        check("t6_eval_data", rd, 6);
        check("t6_err", e, 0);
        send_token(0, 4'd1, acc, pp, pq, e, rv, rd, ap, aq, ad);
        check("hold_res_valid", rv, 0);
        check("hold_res_data", rd, 6);

        // randomized token streams against a queue model
        for (int s = 0; s < 8; s++) begin
            do_reset();
            mq.delete();
            m_err = 0;
            for (int t = 0; t < 40; t++) begin
                bit op, x_acc, x_push, x_pop, x_res, x_ap;
                int d, x_rd, x_din, r, sz;
                r  = $urandom_range(0, 99);
                sz = mq.size();
                op = 0;
                d  = $urandom_range(0, 15);
                if (r < 4) begin
                    op = 1'($urandom_range(0, 1));
                end else if (sz < 2) begin
                    if (sz == 1 && r < 30) begin op = 1; d = 3; end
                end else if (sz == DEPTH || r < 45) begin
                    op = 1; d = $urandom_range(0, 2);
                end
                x_acc = !m_err; x_push = 0; x_pop = 0; x_res = 0; x_ap = 0;
                x_rd = 0; x_din = 0;
                if (!m_err) begin
                    if (!op) begin
                        if (mq.size() == DEPTH) m_err = 1;
                        else begin mq.push_back(d); x_push = 1; end
                    end else if ((d % 4) == 3) begin
                        if (mq.size() != 1) m_err = 1;
                        else begin x_pop = 1; x_res = 1; x_rd = mq[0]; mq.delete(); end
                    end else begin
                        if (mq.size() < 2) m_err = 1;
                        else begin
                            int a, b, f;
                            b = mq.pop_back();
                            a = mq.pop_back();
                            case (d % 4)
                                0:       f = a + b;
                                1:       f = a - b;
                                default: f = a * b;
                            endcase
                            f = f & 15;
                            mq.push_back(f);
                            x_pop = 1; x_ap = 1; x_din = f;
                        end
                    end
                end
                send_token(op, 4'(d), acc, pp, pq, e, rv, rd, ap, aq, ad);
                check("rnd_acc", acc, x_acc);
                check("rnd_err", e, m_err);
                check("rnd_strobes", {pp, pq}, {x_push, x_pop});
                check("rnd_res_valid", rv, x_res);
                if (x_res) check("rnd_res_data", rd, x_rd);
                if (x_ap) check("rnd_apply_din", ad, x_din);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
